// File: rtl/mm_pkg.sv
// Shared types and default sizes for the guess-history store.
//   DEF_PEGS / DEF_COLOR_W / DEF_TURNS : default geometry used by the interface and top
//   color_t / guess_t                  : one peg colour / one full guess (peg 0 in LSBs)
//   view_mode_e                        : live vs. browse presentation
//   fb_t                               : per-turn feedback record
package mm_pkg;

  localparam int unsigned DEF_PEGS    = 4;
  localparam int unsigned DEF_COLOR_W = 3;
  localparam int unsigned DEF_TURNS   = 8;
  localparam int unsigned DEF_FW      = $clog2(DEF_PEGS + 1);

  typedef logic [DEF_COLOR_W-1:0] color_t;
  typedef color_t [DEF_PEGS-1:0]  guess_t;

  typedef enum logic {
    VIEW_LIVE   = 1'b0,
    VIEW_BROWSE = 1'b1
  } view_mode_e;

  typedef struct packed {
    logic [DEF_FW-1:0] exact;
    logic [DEF_FW-1:0] partial;
    logic              valid;
  } fb_t;

endpackage

// File: rtl/guess_history_buf_if.sv
// Bus between the guess-entry/browse controls (master) and the history store (slave).
//   master drives : mode, store, guess_in, fb_wr, fb_exact, fb_partial, btn_up, btn_down
//   slave drives  : sel_guess, sel_exact, sel_partial, sel_fb_valid, sel_turn, turn_count,
//                   empty, full, overflow
interface guess_history_buf_if
  import mm_pkg::*;
#(
  parameter int unsigned PEGS    = DEF_PEGS,
  parameter int unsigned COLOR_W = DEF_COLOR_W,
  parameter int unsigned TURNS   = DEF_TURNS
);
  localparam int unsigned TW = $clog2(TURNS);
  localparam int unsigned FW = $clog2(PEGS + 1);
  localparam int unsigned GW = PEGS * COLOR_W;

  logic          mode;
  logic          store;
  logic [GW-1:0] guess_in;
  logic          fb_wr;
  logic [FW-1:0] fb_exact;
  logic [FW-1:0] fb_partial;
  logic          btn_up;
  logic          btn_down;

  logic [GW-1:0] sel_guess;
  logic [FW-1:0] sel_exact;
  logic [FW-1:0] sel_partial;
  logic          sel_fb_valid;
  logic [TW-1:0] sel_turn;
  logic [TW:0]   turn_count;
  logic          empty;
  logic          full;
  logic          overflow;

  modport master (
    output mode, store, guess_in, fb_wr, fb_exact, fb_partial, btn_up, btn_down,
    input  sel_guess, sel_exact, sel_partial, sel_fb_valid, sel_turn, turn_count,
           empty, full, overflow
  );

  modport slave (
    input  mode, store, guess_in, fb_wr, fb_exact, fb_partial, btn_up, btn_down,
    output sel_guess, sel_exact, sel_partial, sel_fb_valid, sel_turn, turn_count,
           empty, full, overflow
  );

endinterface

// File: rtl/hist_regfile.sv
// TURNS-deep history array: one guess + feedback record per turn.
//   clk          : clock
//   i_clr        : synchronous clear of every entry (wins over writes)
//   i_gw_*       : guess write port; also clears that entry's feedback
//   i_fw_*       : feedback write port; sets that entry's valid flag
//   i_rd_idx     : asynchronous read index
//   o_rd_*       : contents of entry i_rd_idx (pre-write values on a write cycle)
module hist_regfile #(
  parameter int unsigned TURNS = 8,
  parameter int unsigned GW    = 12,
  parameter int unsigned FW    = 3,
  parameter int unsigned TW    = $clog2(TURNS)
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_gw_en,
  input  logic [TW-1:0] i_gw_idx,
  input  logic [GW-1:0] i_gw_data,
  input  logic          i_fw_en,
  input  logic [TW-1:0] i_fw_idx,
  input  logic [FW-1:0] i_fw_exact,
  input  logic [FW-1:0] i_fw_partial,
  input  logic [TW-1:0] i_rd_idx,
  output logic [GW-1:0] o_rd_guess,
  output logic [FW-1:0] o_rd_exact,
  output logic [FW-1:0] o_rd_partial,
  output logic          o_rd_valid
);

  logic [GW-1:0] r_guess   [TURNS];
  logic [FW-1:0] r_exact   [TURNS];
  logic [FW-1:0] r_partial [TURNS];
  logic          r_valid   [TURNS];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(TURNS); i++) begin
        r_guess[i]   <= '0;
        r_exact[i]   <= '0;
        r_partial[i] <= '0;
        r_valid[i]   <= 1'b0;
      end
    end else begin
      // The top never aims both ports at the same entry in one cycle.
      if (i_gw_en) begin
        r_guess[i_gw_idx]   <= i_gw_data;
        r_exact[i_gw_idx]   <= '0;
        r_partial[i_gw_idx] <= '0;
        r_valid[i_gw_idx]   <= 1'b0;
      end
      if (i_fw_en) begin
        r_exact[i_fw_idx]   <= i_fw_exact;
        r_partial[i_fw_idx] <= i_fw_partial;
        r_valid[i_fw_idx]   <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_guess   = r_guess[i_rd_idx];
    o_rd_exact   = r_exact[i_rd_idx];
    o_rd_partial = r_partial[i_rd_idx];
    o_rd_valid   = r_valid[i_rd_idx];
  end

endmodule

// File: rtl/guess_history_buf.sv
// Guess-history store with live and browse views; all outputs registered.
//   clk   : clock
//   reset : synchronous, active-high; clears history, counters and outputs
//   bus   : slave side of guess_history_buf_if (controls in, selected turn + status out)
module guess_history_buf
  import mm_pkg::*;
#(
  parameter int unsigned PEGS    = DEF_PEGS,
  parameter int unsigned COLOR_W = DEF_COLOR_W,
  parameter int unsigned TURNS   = DEF_TURNS
) (
  input logic                clk,
  input logic                reset,
  guess_history_buf_if.slave bus
);

  localparam int unsigned TW = $clog2(TURNS);
  localparam int unsigned FW = $clog2(PEGS + 1);
  localparam int unsigned GW = PEGS * COLOR_W;
  localparam logic [TW:0] FullCount = (TW + 1)'(TURNS);

  view_mode_e    w_mode;
  logic          w_empty, w_full;
  logic          w_store_ok, w_fb_ok, w_ovf_d;
  logic [TW:0]   w_count_d;
  logic [TW-1:0] w_store_idx, w_latest_pre, w_sel_d;

  logic [GW-1:0] w_rd_guess, w_guess_d;
  logic [FW-1:0] w_rd_exact, w_rd_partial, w_exact_d, w_partial_d;
  logic          w_rd_valid, w_valid_d;

  logic [TW:0]   r_count;
  logic [TW-1:0] r_sel;
  logic [GW-1:0] r_guess;
  logic [FW-1:0] r_exact, r_partial;
  logic          r_valid, r_ovf, r_empty, r_full;

  assign w_mode = view_mode_e'(bus.mode);

  always_comb begin
    w_empty      = (r_count == '0);
    w_full       = (r_count == FullCount);
    w_store_ok   = bus.store && (w_mode == VIEW_LIVE) && !w_full;
    // A browse-mode store is dropped silently, even when full.
    w_ovf_d      = bus.store && (w_mode == VIEW_LIVE) && w_full;
    w_fb_ok      = bus.fb_wr && !w_empty;
    w_count_d    = r_count + {{TW{1'b0}}, w_store_ok};
    w_store_idx  = TW'(r_count);
    w_latest_pre = TW'(r_count - 1'b1);
  end

  always_comb begin
    w_sel_d = r_sel;
    if (w_mode == VIEW_LIVE) begin
      w_sel_d = (w_count_d == '0) ? '0 : TW'(w_count_d - 1'b1);
    end else if (w_empty) begin
      w_sel_d = '0;
    end else if (bus.btn_up && !bus.btn_down && (r_sel != w_latest_pre)) begin
      w_sel_d = r_sel + 1'b1;
    end else if (bus.btn_down && !bus.btn_up && (r_sel != '0)) begin
      w_sel_d = r_sel - 1'b1;
    end
  end

  hist_regfile #(
    .TURNS (TURNS),
    .GW    (GW),
    .FW    (FW),
    .TW    (TW)
  ) u_regfile (
    .clk          (clk),
    .i_clr        (reset),
    .i_gw_en      (w_store_ok),
    .i_gw_idx     (w_store_idx),
    .i_gw_data    (bus.guess_in),
    .i_fw_en      (w_fb_ok),
    .i_fw_idx     (w_latest_pre),
    .i_fw_exact   (bus.fb_exact),
    .i_fw_partial (bus.fb_partial),
    .i_rd_idx     (w_sel_d),
    .o_rd_guess   (w_rd_guess),
    .o_rd_exact   (w_rd_exact),
    .o_rd_partial (w_rd_partial),
    .o_rd_valid   (w_rd_valid)
  );

  // The array read reflects pre-edge contents, so writes landing on the entry about to be
  // shown are forwarded here to keep outputs consistent with the array after the edge.
  always_comb begin
    w_guess_d   = w_rd_guess;
    w_exact_d   = w_rd_exact;
    w_partial_d = w_rd_partial;
    w_valid_d   = w_rd_valid;
    if (w_store_ok && (w_sel_d == w_store_idx)) begin
      w_guess_d   = bus.guess_in;
      w_exact_d   = '0;
      w_partial_d = '0;
      w_valid_d   = 1'b0;
    end
    if (w_fb_ok && (w_sel_d == w_latest_pre)) begin
      w_exact_d   = bus.fb_exact;
      w_partial_d = bus.fb_partial;
      w_valid_d   = 1'b1;
    end
    if (w_count_d == '0) begin
      w_guess_d   = '0;
      w_exact_d   = '0;
      w_partial_d = '0;
      w_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_sel     <= '0;
      r_guess   <= '0;
      r_exact   <= '0;
      r_partial <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_sel     <= w_sel_d;
      r_guess   <= w_guess_d;
      r_exact   <= w_exact_d;
      r_partial <= w_partial_d;
      r_valid   <= w_valid_d;
      r_ovf     <= w_ovf_d;
      r_empty   <= (w_count_d == '0);
      r_full    <= (w_count_d == FullCount);
    end
  end

  always_comb begin
    bus.sel_guess    = r_guess;
    bus.sel_exact    = r_exact;
    bus.sel_partial  = r_partial;
    bus.sel_fb_valid = r_valid;
    bus.sel_turn     = r_sel;
    bus.turn_count   = r_count;
    bus.empty        = r_empty;
    bus.full         = r_full;
    bus.overflow     = r_ovf;
  end

endmodule

// File: tb/tb_guess_history_buf.sv
// Self-checking bench for guess_history_buf: directed scenarios followed by random traffic,
// all compared each cycle against a turn-list reference model.
module tb_guess_history_buf;
  import mm_pkg::*;

  localparam int unsigned PEGS    = DEF_PEGS;
  localparam int unsigned COLOR_W = DEF_COLOR_W;
  localparam int unsigned TURNS   = DEF_TURNS;
  localparam int unsigned TW      = $clog2(TURNS);
  localparam int unsigned FW      = $clog2(PEGS + 1);
  localparam int unsigned GW      = PEGS * COLOR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  guess_history_buf_if #(.PEGS(PEGS), .COLOR_W(COLOR_W), .TURNS(TURNS)) u_if ();

  guess_history_buf #(
    .PEGS    (PEGS),
    .COLOR_W (COLOR_W),
    .TURNS   (TURNS)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a list of stored turns plus the index being viewed.
  logic [GW-1:0] m_guess [TURNS];
  int            m_ex    [TURNS];
  int            m_pa    [TURNS];
  bit            m_val   [TURNS];
  int            m_n;
  int            m_sel;
  bit            m_ovf;

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < int'(TURNS); i++) begin
        m_guess[i] = '0; m_ex[i] = 0; m_pa[i] = 0; m_val[i] = 0;
      end
      m_n = 0; m_sel = 0; m_ovf = 0;
    end else begin
      m_ovf = 0;
      if (u_if.fb_wr && m_n > 0) begin
        m_ex[m_n-1]  = int'(u_if.fb_exact);
        m_pa[m_n-1]  = int'(u_if.fb_partial);
        m_val[m_n-1] = 1;
      end
      if (u_if.store && !u_if.mode) begin
        if (m_n < int'(TURNS)) begin
          m_guess[m_n] = u_if.guess_in;
          m_ex[m_n] = 0; m_pa[m_n] = 0; m_val[m_n] = 0;
          m_n++;
        end else begin
          m_ovf = 1;
        end
      end
      if (!u_if.mode) begin
        m_sel = (m_n > 0) ? m_n - 1 : 0;
      end else if (m_n == 0) begin
        m_sel = 0;
      end else if (u_if.btn_up && !u_if.btn_down) begin
        if (m_sel < m_n - 1) m_sel++;
      end else if (u_if.btn_down && !u_if.btn_up) begin
        if (m_sel > 0) m_sel--;
      end
    end
  endtask

  task automatic check_all();
    logic [GW-1:0] eg;
    int ee, ep;
    bit ev;
    eg = '0; ee = 0; ep = 0; ev = 0;
    if (m_n > 0) begin
      eg = m_guess[m_sel]; ee = m_ex[m_sel]; ep = m_pa[m_sel]; ev = m_val[m_sel];
    end
    check("sel_guess",    64'(u_if.sel_guess),    64'(eg));
    check("sel_exact",    64'(u_if.sel_exact),    64'(ee));
    check("sel_partial",  64'(u_if.sel_partial),  64'(ep));
    check("sel_fb_valid", 64'(u_if.sel_fb_valid), 64'(ev));
    check("sel_turn",     64'(u_if.sel_turn),     64'(m_sel));
    check("turn_count",   64'(u_if.turn_count),   64'(m_n));
    check("empty",        64'(u_if.empty),        64'(m_n == 0));
    check("full",         64'(u_if.full),         64'(m_n == int'(TURNS)));
    check("overflow",     64'(u_if.overflow),     64'(m_ovf));
  endtask

  // One clock: inputs already driven, model follows the edge, outputs checked at negedge,
  // then single-cycle pulses are dropped (mode persists).
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    u_if.store = 1'b0; u_if.fb_wr = 1'b0; u_if.btn_up = 1'b0; u_if.btn_down = 1'b0;
  endtask

  task automatic do_store(input logic [GW-1:0] g);
    u_if.store = 1'b1; u_if.guess_in = g; tick();
  endtask

  task automatic do_fb(input int ex, input int pa);
    u_if.fb_wr = 1'b1; u_if.fb_exact = FW'(ex); u_if.fb_partial = FW'(pa); tick();
  endtask

  task automatic do_btn(input bit up, input bit dn);
    u_if.btn_up = up; u_if.btn_down = dn; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1;
    u_if.mode = 1'b0; u_if.store = 1'b0; u_if.guess_in = '0; u_if.fb_wr = 1'b0;
    u_if.fb_exact = '0; u_if.fb_partial = '0; u_if.btn_up = 1'b0; u_if.btn_down = 1'b0;
    @(negedge clk);
    tick();
    check("rst_empty", 64'(u_if.empty), 64'(1));

    // First store and feedback, including same-cycle store + feedback.
    do_store(12'h8D1);
    check("first_guess", 64'(u_if.sel_guess), 64'h8D1);
    do_fb(2, 1);
    check("first_exact", 64'(u_if.sel_exact), 64'd2);
    u_if.fb_wr = 1'b1; u_if.fb_exact = FW'(3); u_if.fb_partial = FW'(0);
    do_store(12'h2A5);
    check("new_turn_fbv", 64'(u_if.sel_fb_valid), 64'd0);
    check("old_turn_ex", 64'(m_ex[0]), 64'd3);

    // Fill to full, then overflow.
    for (int i = 2; i < int'(TURNS); i++) do_store(GW'(12'h100 + i * 37));
    check("full_flag", 64'(u_if.full), 64'd1);
    do_store(12'hFFF);
    check("ovf_pulse", 64'(u_if.overflow), 64'd1);
    check("entry7_kept", 64'(u_if.sel_guess), 64'(GW'(12'h100 + 7 * 37)));
    tick();
    check("ovf_drop", 64'(u_if.overflow), 64'd0);

    // Browse saturation with five turns.
    do_reset();
    for (int i = 0; i < 5; i++) do_store(GW'(12'h321 + i * 91));
    u_if.mode = 1'b1;
    for (int i = 0; i < 6; i++) do_btn(1'b0, 1'b1);
    check("down_sat", 64'(u_if.sel_turn), 64'd0);
    for (int i = 0; i < 7; i++) do_btn(1'b1, 1'b0);
    check("up_sat", 64'(u_if.sel_turn), 64'd4);
    do_btn(1'b0, 1'b1);
    do_btn(1'b1, 1'b1);
    check("both_btn", 64'(u_if.sel_turn), 64'd3);
    u_if.mode = 1'b0; tick();
    check("snap_live", 64'(u_if.sel_turn), 64'd4);

    // Browse while empty; browse-mode store dropped.
    do_reset();
    u_if.mode = 1'b1;
    do_btn(1'b1, 1'b0); do_btn(1'b0, 1'b1);
    do_store(12'h555);
    check("browse_store", 64'(u_if.turn_count), 64'd0);

    // Reset mid-browse, then restart from entry 0.
    u_if.mode = 1'b0;
    for (int i = 0; i < 6; i++) do_store(GW'(12'h0A0 + i));
    u_if.mode = 1'b1;
    do_btn(1'b0, 1'b1); do_btn(1'b0, 1'b1);
    check("pre_rst_sel", 64'(u_if.sel_turn), 64'd3);
    do_reset();
    u_if.mode = 1'b0;
    do_store(12'h7E4);
    check("post_rst_e0", 64'(u_if.sel_guess), 64'h7E4);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15, 0) == 0) u_if.mode = ~u_if.mode;
      reset         = ($urandom_range(199, 0) == 0);
      u_if.store    = ($urandom_range(3, 0) == 0);
      u_if.guess_in = GW'($urandom);
      u_if.fb_wr    = ($urandom_range(3, 0) == 0);
      u_if.fb_exact   = FW'($urandom_range(PEGS, 0));
      u_if.fb_partial = FW'($urandom_range(PEGS, 0));
      u_if.btn_up   = ($urandom_range(2, 0) == 0);
      u_if.btn_down = ($urandom_range(2, 0) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
